// File: rtl/argext_stream.sv
// Streaming arg-min/arg-max: tracks the extreme value of a frame, its position and the
// frame length, and presents the result until the consumer takes it.
module argext_stream #(
    parameter int WIDTH   = 3,
    parameter int MAX_LEN = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W:0]   out_count,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LEN);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             beat, take, at_max, frame_end, frame_err;

    assign in_ready  = rst_n & (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign beat      = in_valid & in_ready;
    assign at_max    = (cnt_d == MAX_CNT);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        best_d    = best_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        take      = 1'b0;
        frame_end = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    take   = 1'b1;
                    mode_d = mode;
                    best_d = in_data;
                    idx_d  = '0;
                    cnt_d  = (IDX_W+1)'(1);
                end
            end
            ACCUM: begin
                if (beat) begin
                    take  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    // Strict comparison: ties keep the earlier index.
                    if (mode_q ? (in_data > best_q) : (in_data < best_q)) begin
                        best_d = in_data;
                        idx_d  = cnt_q[IDX_W-1:0];
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            frame_end = in_last | at_max;
            frame_err = ~in_last & at_max;
            state_d   = frame_end ? HOLD : ACCUM;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: every register, including the result fields, is reset so an aborted frame never shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            best_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            out_value <= '0;
            out_index <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (frame_end) begin
                out_value <= best_d;
                out_index <= idx_d;
                out_count <= cnt_d;
                out_err   <= frame_err;
            end
        end
    end

endmodule

// File: doc/argext_stream.md
# argext_stream

Streaming arg-min/arg-max unit: accepts a frame of up to MAX_LEN unsigned values, one per accepted beat. It returns the extreme value, its 0-based position in the frame and the frame length. The block is the parametrised, sequential successor of the team's fixed four-input minimum selector. It adds configurable data width and frame depth, a per-frame min/max mode, valid/ready handshakes and a frame-overflow guard. It sits between a sample producer and any consumer that needs "which element won".

## Interface
- WIDTH, 3: data width in bits; values are compared as unsigned.
- MAX_LEN, 4: maximum elements per frame, must be at least 2.
- IDX_W, 2: index width, must be at least clog2(MAX_LEN); the count output is IDX_W+1 bits.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  element value.
- in_last  in  1  beat is the final element of its frame.
- mode  in  1  0 = arg-min, 1 = arg-max; sampled only on the first beat of a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_value  out  WIDTH  winning value.
- out_index  out  IDX_W  0-based position of the winner within its frame.
- out_count  out  IDX_W+1  number of elements in the frame, from 1 to MAX_LEN.
- out_err  out  1  frame was force-terminated at MAX_LEN without in_last.

## Operation
- A beat on either port transfers only when valid and ready are both high at a clk edge.
- **States:**
  - IDLE: no partial frame.
  - ACCUM: partial frame held.
  - HOLD: result presented.
- **in_ready** = rst_n & (state != HOLD). It is combinational and does not depend on in_valid.
- **IDLE, on a beat:**
  - Latch mode.
  - Best value ← in_data, best index ← 0, count ← 1.
  - Go to HOLD if in_last is set or MAX_LEN is reached, otherwise go to ACCUM.
- **ACCUM, on a beat:**
  - Position p = current count.
  - The new value replaces the best only if it is strictly less (mode 0) or strictly greater (mode 1) than the current best.
  - Ties keep the earlier index.
  - count ← count+1.
- **Termination:**
  - The frame ends on a beat with in_last = 1, or on the beat that makes count equal MAX_LEN.
  - In the MAX_LEN case with in_last = 0, out_err = 1.
  - If in_last = 1 on the MAX_LEN-th beat, out_err = 0.
  - Either way the state moves to HOLD.
- **HOLD:**
  - out_valid = 1.
  - All output fields stay stable until out_ready is high.
  - When out_ready is high: go to IDLE and drop out_valid.
- **Overflow continuation:** after a forced termination, the next accepted beat starts a new frame at index 0.
- **mode changes:** a change of mode mid-frame has no effect until the next frame's first beat.
- **Width rules:**
  - out_count counts up to MAX_LEN, so it needs IDX_W+1 bits.
  - out_index never exceeds MAX_LEN-1.
- **Reset:**
  - Asserting rst_n low at any time aborts a partial or held frame.
  - The aborted result is never presented.

## Timing
- **Reset values:**
  - State = IDLE.
  - out_valid = 0, out_value = 0, out_index = 0, out_count = 0, out_err = 0.
  - in_ready = 0 while rst_n is low, and 1 after release.
- **Latency:** out_valid rises at the edge that accepts the terminating beat, so results are visible one cycle after the final input beat.
- **Throughput:** one element per cycle within a frame.
- **Frame turnaround:** one bubble per frame. in_ready is low for at least one cycle in HOLD.
  - With out_ready held high, HOLD lasts exactly one cycle.
  - A single-element frame therefore sustains one frame every 2 cycles.
- **Output hold:** result fields are registered and change only on entry to HOLD or on reset.
- **Ready rule:** out_ready may be asserted before out_valid; it has no effect outside HOLD.
- **in_valid low:** in_valid low in ACCUM simply stalls; no timeout.

## Test plan
- **Min frame:** MAX_LEN = 4, mode 0; feed 5, 2, 7, 2 with last on the 4th beat → one cycle later out_valid = 1, value 2, index 1 (the tie keeps the earlier position), count 4, err 0.
- **Max frame:** mode 1; feed 3, 6, 6, 1 with last on the 4th beat → value 6, index 1, count 4. Toggling mode during beats 2–4 leaves this result unchanged.
- **Backpressure:** feed a single beat 4 with last, hold out_ready = 0 for 5 cycles → out_valid and all fields stay constant and in_ready stays 0. Then pulse out_ready → IDLE on the next cycle with in_ready = 1.
- **Overflow:** feed 6, 1, 3, 0, 2 with no last → first result is value 0, index 3, count 4, err 1. The 5th beat starts a new frame; sending last on it gives value 2, index 0, count 1, err 0.
- **Reset:** assert rst_n low after two beats → outputs go to 0 immediately (asynchronous). After release, frame 7 (last) → value 7, index 0, count 1.
- **Wide config:** WIDTH = 8, MAX_LEN = 8, IDX_W = 3, mode 0; feed 200, 13, 255, 0, 90, 0, 1, 12 with last on the 8th beat → value 0, index 3, count 8, err 0.
